m_ifetch: RTL and testbench
===========================

M_IFETCH -- requirements
Module: m_ifetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Parameter: DEPTH, 2, instruction-queue capacity in entries; the only supported value is 2.
REQ-003 w_clk  in  1  single clock; all state updates on posedge.
REQ-004 w_rst_n  in  1  reset; synchronous, active-low.
REQ-005 w_imem_req  out  1  instruction-memory read request for this cycle.
REQ-006 w_imem_addr  out  32  byte address of the request; bits[1:0] are always 0.
REQ-007 w_imem_data  in  32  read data; valid in the cycle after the request (fixed 1-cycle latency).
REQ-008 w_redirect  in  1  flush and restart fetch (branch/jump from execute).
REQ-009 w_redirect_pc  in  32  restart address; sampled when w_redirect=1.
REQ-010 w_out_valid  out  1  head entry is valid toward execute.
REQ-011 w_out_ready  in  1  execute accepts the head entry.
REQ-012 w_out_pc  out  32  PC of the head entry.
REQ-013 w_out_inst  out  32  instruction word of the head entry.

Function
REQ-014 State: r_fetch_pc (next address to request), a 2-entry FIFO of {pc, inst}, count (0..2), an in-flight flag, and the in-flight PC.
REQ-015 pop = w_out_valid & w_out_ready; w_out_valid = (count != 0); w_out_pc and w_out_inst come from FIFO head registers with no combinational path from w_imem_data.
REQ-016 w_imem_req = ~w_redirect & (count + inflight - pop < 2); w_imem_addr = r_fetch_pc.
REQ-017 On a request: r_fetch_pc <= r_fetch_pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0); inflight <= 1; in-flight PC <= r_fetch_pc.
REQ-018 In the cycle after an unkilled request: push {in-flight PC, w_imem_data}; inflight clears unless a new request is issued that cycle.
REQ-019 Push and pop in the same cycle leave count unchanged and preserve order.
REQ-020 Full (count=2, or count+inflight=2 with no pop): w_imem_req=0 and r_fetch_pc holds.
REQ-021 Empty: w_out_valid=0; w_out_pc and w_out_inst are don't-care.
REQ-022 Latency: a request in cycle N produces w_out_valid=1 in cycle N+2.
REQ-023 Throughput: with w_out_ready held at 1, the block delivers one instruction per cycle in steady state.
REQ-024 Redirect takes priority over every other action:
- count <= 0
- the in-flight response is killed (never pushed)
- r_fetch_pc <= {w_redirect_pc[31:2], 2'b00}
- w_imem_req=0 in the redirect cycle
- the first new request is issued in the following cycle
REQ-025 A pop in a redirect cycle counts as completed; the consumer issuing the redirect discards it.
REQ-026 w_out_valid is 0 in the cycle after a redirect.
REQ-027 Misaligned w_redirect_pc has bits[1:0] forced to 0; no exception is raised.

Reset
REQ-028 While w_rst_n=0 at posedge: count=0, inflight=0, r_fetch_pc=RESET_PC.
REQ-029 In any cycle with w_rst_n=0: w_out_valid=0 and w_imem_req=0.
REQ-030 Reset overrides redirect.
REQ-031 Reset asserted mid-operation discards all queued and in-flight instructions.
REQ-032 The first request (address RESET_PC) is issued in the first cycle with w_rst_n=1.

Verification
REQ-033 Streaming: release reset, w_out_ready=1, imem model returns data=addr -> w_out_valid rises 2 cycles after the first request; w_out_pc/w_out_inst = 0,4,8,12 on consecutive cycles.
REQ-034 Backpressure: w_out_ready=0 from reset -> count reaches 2 and w_imem_req drops with w_imem_addr=8; head stays pc=0; raising ready yields 0,4,8 with no gaps or duplicates.
REQ-035 Redirect while full with a request in flight, w_redirect_pc=32'h40 -> next delivered pcs are 0x40, 0x44; pcs 0x4 and 0x8 never appear after the redirect.
REQ-036 Misaligned redirect to 32'h43 -> w_imem_addr=32'h40; first delivered pc=0x40.
REQ-037 Wrap: RESET_PC=32'hFFFF_FFF8 -> delivered pcs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-038 Reset pulsed for one cycle mid-stream -> w_out_valid=0 and w_imem_req=0 that cycle; afterwards fetch restarts at RESET_PC with no stale entries.

Source files
------------

// File: rtl/m_ifetch.sv
// m_ifetch: instruction fetch front end. Issues sequential reads to an
// instruction memory with a fixed one-cycle read latency and queues the
// returned {pc, inst} pairs in a two-entry FIFO toward execute. A redirect
// flushes the queue, kills the in-flight read and restarts fetch.
//
// Output handshake: an entry transfers on any cycle where w_out_valid and
// w_out_ready are both 1 at the rising clock edge. w_out_valid never depends
// on w_out_ready, and the head fields come only from registers.
module m_ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        w_clk,
   input  logic        w_rst_n,
   output logic        w_imem_req,
   output logic [31:0] w_imem_addr,
   input  logic [31:0] w_imem_data,
   input  logic        w_redirect,
   input  logic [31:0] w_redirect_pc,
   output logic        w_out_valid,
   input  logic        w_out_ready,
   output logic [31:0] w_out_pc,
   output logic [31:0] w_out_inst
);

   // Queue capacity; only two entries are implemented by the storage below.
   localparam logic [2:0] CAP = 3'(DEPTH);

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        inflight_q, inflight_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] pc0_q, pc0_d, inst0_q, inst0_d;   // head entry
   logic [31:0] pc1_q, pc1_d, inst1_q, inst1_d;   // second entry

   logic        out_valid;
   logic        pop;
   logic        push;
   logic        req;
   logic [2:0]  occupancy;
   logic [1:0]  wr_idx;

   // Handshake, request decision and occupancy after this cycle's pop.
   always_comb begin
      out_valid = w_rst_n & (count_q != 2'd0);
      pop       = out_valid & w_out_ready;
      // A response landing in a redirect cycle belongs to the old path.
      push      = inflight_q & ~w_redirect;
      // Entries held plus the one arriving, minus the one leaving; pop
      // implies count_q >= 1 so this never underflows.
      occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
      req       = w_rst_n & ~w_redirect & (occupancy < CAP);
      wr_idx    = count_q - {1'b0, pop};
   end

   // Next-state: FIFO shift/write, counters, fetch pointer, redirect flush.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = req;
      inflight_pc_d = inflight_pc_q;
      count_d       = count_q + {1'b0, push} - {1'b0, pop};
      pc0_d         = pc0_q;
      inst0_d       = inst0_q;
      pc1_d         = pc1_q;
      inst1_d       = inst1_q;

      // Popping shifts the second entry into the head.
      if (pop) begin
         pc0_d   = pc1_q;
         inst0_d = inst1_q;
      end

      // The write slot is computed after the shift so order is preserved.
      if (push) begin
         if (wr_idx == 2'd0) begin
            pc0_d   = inflight_pc_q;
            inst0_d = w_imem_data;
         end else begin
            pc1_d   = inflight_pc_q;
            inst1_d = w_imem_data;
         end
      end

      if (req) begin
         fetch_pc_d    = fetch_pc_q + 32'd4;
         inflight_pc_d = fetch_pc_q;
      end

      // Redirect wins over everything; low address bits are dropped.
      if (w_redirect) begin
         count_d    = 2'd0;
         inflight_d = 1'b0;
         fetch_pc_d = w_redirect_pc & 32'hFFFF_FFFC;
      end
   end

   // Control state with synchronous active-low reset (overrides redirect).
   always_ff @(posedge w_clk) begin
      if (!w_rst_n) begin
         fetch_pc_q <= RESET_PC;
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
      end
   end

   // Data storage; contents are meaningless while the matching count/flag is clear.
   always_ff @(posedge w_clk) begin
      inflight_pc_q <= inflight_pc_d;
      pc0_q         <= pc0_d;
      inst0_q       <= inst0_d;
      pc1_q         <= pc1_d;
      inst1_q       <= inst1_d;
   end

   assign w_imem_req  = req;
   assign w_imem_addr = fetch_pc_q;
   assign w_out_valid = out_valid;
   assign w_out_pc    = pc0_q;
   assign w_out_inst  = inst0_q;

endmodule

// File: tb/tb_m_ifetch.sv
// Bench for m_ifetch: directed scenarios plus a randomized run checked
// against a "next expected pc" stream model with an instruction memory
// whose contents are a simple function of the address.
module tb_m_ifetch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] key;

  // second instance for the address-wrap scenario
  logic        rst2_n;
  logic        redirect2;
  logic [31:0] redirect_pc2;
  logic        ready2;
  logic        imem2_req;
  logic [31:0] imem2_addr;
  logic [31:0] imem2_data;
  logic        valid2;
  logic [31:0] pc2;
  logic [31:0] inst2;

  int errors = 0;
  int checks = 0;

  logic [31:0] got_pc_q[$];
  logic [31:0] got_inst_q[$];

  m_ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .w_clk(clk), .w_rst_n(rst_n),
    .w_imem_req(imem_req), .w_imem_addr(imem_addr), .w_imem_data(imem_data),
    .w_redirect(redirect), .w_redirect_pc(redirect_pc),
    .w_out_valid(out_valid), .w_out_ready(out_ready),
    .w_out_pc(out_pc), .w_out_inst(out_inst)
  );

  m_ifetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
    .w_clk(clk), .w_rst_n(rst2_n),
    .w_imem_req(imem2_req), .w_imem_addr(imem2_addr), .w_imem_data(imem2_data),
    .w_redirect(redirect2), .w_redirect_pc(redirect_pc2),
    .w_out_valid(valid2), .w_out_ready(ready2),
    .w_out_pc(pc2), .w_out_inst(inst2)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a, input logic [31:0] k);
    return a ^ k;
  endfunction

  // instruction memories: fixed one-cycle read latency
  always @(posedge clk) imem_data  <= imem_req  ? word_of(imem_addr, key) : 32'hBAD0_BAD0;
  always @(posedge clk) imem2_data <= imem2_req ? ~imem2_addr : 32'hBAD0_BAD0;

  // scoreboard collector: records every completed transfer (redirect-cycle pops are discarded)
  always @(negedge clk) begin
    if (rst_n && !redirect && out_valid && out_ready) begin
      got_pc_q.push_back(out_pc);
      got_inst_q.push_back(out_inst);
    end
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs c%0d: valid=%b req=%b expected 0 0", c, out_valid, imem_req);
      end
      tick();
    end
    rst_n = 1'b1; redirect = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_after: valid=%b expected 0", out_valid);
    end
    tick();
  endtask

  task automatic test_stream();
    key = 32'h0; rst_n = 1'b0; out_ready = 1'b1; tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c == 1) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_latency c1: valid=%b expected 0", out_valid);
        end
      end
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'(4 * (c - 2)) || out_inst !== 32'(4 * (c - 2))) begin
          errors++;
          $display("FAIL stream_head c%0d: valid=%b pc=%h inst=%h expected 1 %h %h",
                   c, out_valid, out_pc, out_inst, 32'(4 * (c - 2)), 32'(4 * (c - 2)));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    key = 32'h0; rst_n = 1'b0; out_ready = 1'b0; tick();
    rst_n = 1'b1;
    tick(); tick(); tick();   // now in cycle 3 after release
    for (int c = 3; c < 6; c++) begin
      #1;
      checks++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h8 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
        errors++;
        $display("FAIL backpressure_full c%0d: req=%b addr=%h valid=%b pc=%h expected 0 00000008 1 00000000",
                 c, imem_req, imem_addr, out_valid, out_pc);
      end
      tick();
    end
    got_pc_q.delete(); got_inst_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    checks++;
    if (got_pc_q.size() < 3) begin
      errors++;
      $display("FAIL backpressure_count: got %0d transfers expected at least 3", got_pc_q.size());
    end
    for (int i = 0; i < got_pc_q.size(); i++) begin
      checks++;
      if (got_pc_q[i] !== 32'(4 * i) || got_inst_q[i] !== 32'(4 * i)) begin
        errors++;
        $display("FAIL backpressure_order i%0d: pc=%h inst=%h expected %h", i, got_pc_q[i], got_inst_q[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_full();
    logic bad;
    key = 32'h1234_0000; rst_n = 1'b0; out_ready = 1'b0; tick();
    rst_n = 1'b1;
    tick(); tick();           // cycle 2: one queued, one in flight
    redirect = 1'b1; redirect_pc = 32'h40;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL redirect_req: req=%b expected 0", imem_req);
    end
    tick();
    redirect = 1'b0; out_ready = 1'b1;
    got_pc_q.delete(); got_inst_q.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL redirect_after: valid=%b req=%b addr=%h expected 0 1 00000040", out_valid, imem_req, imem_addr);
    end
    for (int c = 0; c < 7; c++) tick();
    checks++;
    if (got_pc_q.size() < 2) begin
      errors++;
      $display("FAIL redirect_count: got %0d transfers expected at least 2", got_pc_q.size());
    end else if (got_pc_q[0] !== 32'h40 || got_pc_q[1] !== 32'h44 ||
                 got_inst_q[0] !== word_of(32'h40, key) || got_inst_q[1] !== word_of(32'h44, key)) begin
      errors++;
      $display("FAIL redirect_first: pcs=%h,%h insts=%h,%h expected 00000040,00000044",
               got_pc_q[0], got_pc_q[1], got_inst_q[0], got_inst_q[1]);
    end
    bad = 1'b0;
    foreach (got_pc_q[i]) if (got_pc_q[i] == 32'h4 || got_pc_q[i] == 32'h8) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL redirect_stale: stale pc 4 or 8 seen=%b expected 0", bad);
    end
  endtask

  task automatic test_misaligned();
    key = $urandom; rst_n = 1'b0; out_ready = 1'b1; tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    redirect = 1'b1; redirect_pc = 32'h43;
    tick();
    redirect = 1'b0;
    got_pc_q.delete(); got_inst_q.delete();
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL misaligned_addr: req=%b addr=%h expected 1 00000040", imem_req, imem_addr);
    end
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if (got_pc_q.size() == 0) begin
      errors++;
      $display("FAIL misaligned_count: got 0 transfers expected at least 1");
    end else if (got_pc_q[0] !== 32'h40 || got_inst_q[0] !== word_of(32'h40, key)) begin
      errors++;
      $display("FAIL misaligned_first: pc=%h inst=%h expected 00000040 %h", got_pc_q[0], got_inst_q[0], word_of(32'h40, key));
    end
  endtask

  task automatic test_reset_mid();
    key = $urandom; rst_n = 1'b0; out_ready = 1'b1; tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    rst_n = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: valid=%b req=%b expected 0 0", out_valid, imem_req);
    end
    tick();
    rst_n = 1'b1; redirect = 1'b0;
    got_pc_q.delete(); got_inst_q.delete();
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_restart: req=%b addr=%h valid=%b expected 1 00000000 0", imem_req, imem_addr, out_valid);
    end
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if (got_pc_q.size() < 3) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d transfers expected at least 3", got_pc_q.size());
    end
    for (int i = 0; i < got_pc_q.size(); i++) begin
      checks++;
      if (got_pc_q[i] !== 32'(4 * i) || got_inst_q[i] !== word_of(32'(4 * i), key)) begin
        errors++;
        $display("FAIL reset_mid_order i%0d: pc=%h inst=%h expected %h", i, got_pc_q[i], got_inst_q[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w[4];
    exp_w = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    rst2_n = 1'b0; ready2 = 1'b1; tick();
    rst2_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c >= 2) begin
        checks++;
        if (valid2 !== 1'b1 || pc2 !== exp_w[c-2] || inst2 !== ~exp_w[c-2]) begin
          errors++;
          $display("FAIL wrap_pc c%0d: valid=%b pc=%h inst=%h expected 1 %h %h",
                   c, valid2, pc2, inst2, exp_w[c-2], ~exp_w[c-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_next;
    int          idle;
    logic        prev_redir;
    key = $urandom; rst_n = 1'b0; out_ready = 1'b1; redirect = 1'b0; tick();
    rst_n = 1'b1;
    exp_next = 32'h0; idle = 0; prev_redir = 1'b0;
    for (int c = 0; c < 600; c++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      #1;
      if (imem_req === 1'b1) begin
        checks++;
        if (imem_addr[1:0] !== 2'b00) begin
          errors++;
          $display("FAIL rand_align c%0d: addr=%h expected low bits 00", c, imem_addr);
        end
      end
      if (redirect) begin
        checks++;
        if (imem_req !== 1'b0) begin
          errors++;
          $display("FAIL rand_redirect_req c%0d: req=%b expected 0", c, imem_req);
        end
        exp_next = {redirect_pc[31:2], 2'b00};
        idle = 0;
      end else begin
        if (prev_redir) begin
          checks++;
          if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_valid_after_redirect c%0d: valid=%b expected 0", c, out_valid);
          end
        end
        if (out_valid === 1'b1) begin
          idle = 0;
          if (out_ready) begin
            checks++;
            if (out_pc !== exp_next || out_inst !== word_of(exp_next, key)) begin
              errors++;
              $display("FAIL rand_stream c%0d: pc=%h inst=%h expected %h %h",
                       c, out_pc, out_inst, exp_next, word_of(exp_next, key));
            end
            exp_next = exp_next + 32'd4;
          end
        end else begin
          idle++;
          checks++;
          if (idle > 2) begin
            errors++;
            $display("FAIL rand_starve c%0d: idle cycles=%0d expected at most 2", c, idle);
          end
        end
      end
      prev_redir = redirect;
      tick();
    end
    redirect = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    key = 32'h0; rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    rst2_n = 1'b0; redirect2 = 1'b0; redirect_pc2 = 32'h0; ready2 = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_misaligned();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
